// File: rtl/vga_scanout_controller_if.sv
// rtl/vga_scanout_controller_if.sv - host command, FIFO and DAC signal bundle for the VGA scanout controller
interface vga_scanout_controller_if;
  logic [2:0]  command;
  logic        clear_command;
  logic        enable_vga_fifo;
  logic [9:0]  fifo_level;
  logic        fifo_empty;
  logic        fifo_read;
  logic [11:0] fifo_data;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        underflow;
  logic        busy;

  // controller side
  modport slave (
    input  command, fifo_level, fifo_empty, fifo_data,
    output clear_command, enable_vga_fifo, fifo_read, rgb, hsync, vsync, underflow, busy
  );

  // host / FIFO / DAC side
  modport master (
    output command, fifo_level, fifo_empty, fifo_data,
    input  clear_command, enable_vga_fifo, fifo_read, rgb, hsync, vsync, underflow, busy
  );
endinterface

// File: rtl/vga_scanout_controller.sv
// rtl/vga_scanout_controller.sv - VGA raster timing and FIFO-fed pixel scanout with command handshake
module vga_scanout_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PREFILL  = 64
) (
  input  logic                     vga_clock,
  input  logic                     reset,
  vga_scanout_controller_if.slave  bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [2:0] VGA_NOP     = 3'd0;
  localparam logic [2:0] VGA_PREPARE = 3'd1;
  localparam logic [2:0] VGA_STOP    = 3'd2;

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [9:0]    PREFILL_C = 10'(PREFILL);

  typedef enum logic [1:0] {ST_IDLE, ST_PREFILL, ST_DISPLAY, ST_STOPPING} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [HW-1:0] r_h_count;
  logic [VW-1:0] r_v_count;
  logic          r_clear_command;
  logic          r_enable;
  logic          r_read_d;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_underflow;

  logic w_cmd_nop, w_accept, w_prepare, w_stop;
  logic w_run, w_active, w_read, w_h_last, w_v_last, w_hsync_n, w_vsync_n;

  // Codes other than PREPARE/STOP behave as NOP, both for acceptance and for releasing the acknowledge.
  assign w_cmd_nop = (bus.command != VGA_PREPARE) && (bus.command != VGA_STOP);
  assign w_accept  = !r_clear_command && !w_cmd_nop;
  assign w_prepare = w_accept && (bus.command == VGA_PREPARE);
  assign w_stop    = w_accept && (bus.command == VGA_STOP);

  assign w_run     = (r_state == ST_DISPLAY) || (r_state == ST_STOPPING);
  assign w_h_last  = (r_h_count == H_LAST_C);
  assign w_v_last  = (r_v_count == V_LAST_C);
  assign w_active  = w_run && (r_h_count < H_ACT_C) && (r_v_count < V_ACT_C);
  assign w_read    = w_active && !bus.fifo_empty;
  assign w_hsync_n = w_run && (r_h_count >= H_SS_C) && (r_h_count < H_SE_C);
  assign w_vsync_n = w_run && (r_v_count >= V_SS_C) && (r_v_count < V_SE_C);

  // Next-state logic; commands invalid for the current state fall through with no change.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_prepare) w_state_next = ST_PREFILL;
      ST_PREFILL:  if (w_stop) w_state_next = ST_IDLE;
                   else if (bus.fifo_level >= PREFILL_C) w_state_next = ST_DISPLAY;
      ST_DISPLAY:  if (w_stop) w_state_next = ST_STOPPING;
      ST_STOPPING: if (w_h_last && w_v_last) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // State register, FIFO writer enable and command acknowledge.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_enable        <= 1'b0;
      r_clear_command <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_enable <= (w_state_next != ST_IDLE);
      if (w_accept)
        r_clear_command <= 1'b1;
      else if (r_clear_command && w_cmd_nop)
        r_clear_command <= 1'b0;
    end
  end

  // Raster counters run only while scanning out; the final wrap returns them to 0 for IDLE.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (!w_run) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_h_last) begin
      r_h_count <= '0;
      r_v_count <= w_v_last ? '0 : r_v_count + 1'b1;
    end else begin
      r_h_count <= r_h_count + 1'b1;
    end
  end

  // Pixel-path registers delayed one cycle to line up with the FIFO read latency; sticky underflow.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_read_d    <= 1'b0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_read_d <= w_read;
      r_hsync  <= !w_hsync_n;
      r_vsync  <= !w_vsync_n;
      if (r_state == ST_IDLE && w_prepare)
        r_underflow <= 1'b0;
      else if (w_active && bus.fifo_empty)
        r_underflow <= 1'b1;
    end
  end

  assign bus.clear_command   = r_clear_command;
  assign bus.enable_vga_fifo = r_enable;
  assign bus.fifo_read       = w_read;
  assign bus.rgb             = r_read_d ? bus.fifo_data : 12'd0;
  assign bus.hsync           = r_hsync;
  assign bus.vsync           = r_vsync;
  assign bus.underflow       = r_underflow;
  assign bus.busy            = (r_state != ST_IDLE);
endmodule

// File: tb/tb_vga_scanout_controller.sv
// tb/tb_vga_scanout_controller.sv - randomized self-checking bench for vga_scanout_controller
module tb_vga_scanout_controller;
  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 6, VF = 1, VSW = 2, VB = 2;
  localparam int PF = 4;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam logic [2:0] NOP = 3'd0, PREP = 3'd1, STOP = 3'd2;

  logic vga_clock = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  vga_scanout_controller_if vif();

  vga_scanout_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PREFILL(PF)
  ) dut (
    .vga_clock(vga_clock),
    .reset(reset),
    .bus(vif)
  );

  always #5 vga_clock = ~vga_clock;

  // FIFO read port: sequentially numbered words, data valid the cycle after a read.
  logic [11:0] fifo_word = 12'd1;
  always @(posedge vga_clock) begin
    if (reset) vif.fifo_data <= 12'd0;
    else if (vif.fifo_read) begin
      vif.fifo_data <= fifo_word;
      fifo_word <= fifo_word + 12'd1;
    end
  end

  // Reference model: raster position derived from cycles since DISPLAY entry.
  int t;
  bit m_prev_read;
  int m_prev_word;
  int m_next_word = 1;
  bit m_hs, m_vs, m_under;
  bit obs_read, obs_hs, obs_vs;

  function automatic void model_start();
    t = 0;
    m_prev_read = 1'b0;
    m_hs = 1'b1;
    m_vs = 1'b1;
  endfunction

  task automatic idle_tick();
    @(posedge vga_clock);
    #1;
  endtask

  // One scanout cycle: drive fifo_empty, compare DUT against model, advance model.
  task automatic disp_cycle(input bit empty_in);
    int h, v;
    bit act, rd;
    logic [11:0] exp_rgb;
    h = t % HT;
    v = (t / HT) % VT;
    act = (h < HA) && (v < VA);
    rd = act && !empty_in;
    exp_rgb = m_prev_read ? 12'(m_prev_word) : 12'd0;
    vif.fifo_empty = empty_in;
    #1;
    obs_read = vif.fifo_read;
    obs_hs = vif.hsync;
    obs_vs = vif.vsync;
    vectors++; if (vif.fifo_read !== rd) begin miscompares++; $display("FAIL fifo_read t=%0d got %b expected %b", t, vif.fifo_read, rd); end
    vectors++; if (vif.rgb !== exp_rgb) begin miscompares++; $display("FAIL rgb t=%0d got %h expected %h", t, vif.rgb, exp_rgb); end
    vectors++; if (vif.hsync !== m_hs) begin miscompares++; $display("FAIL hsync t=%0d got %b expected %b", t, vif.hsync, m_hs); end
    vectors++; if (vif.vsync !== m_vs) begin miscompares++; $display("FAIL vsync t=%0d got %b expected %b", t, vif.vsync, m_vs); end
    vectors++; if (vif.underflow !== m_under) begin miscompares++; $display("FAIL underflow t=%0d got %b expected %b", t, vif.underflow, m_under); end
    vectors++; if (vif.busy !== 1'b1) begin miscompares++; $display("FAIL busy_scan t=%0d got %b expected 1", t, vif.busy); end
    m_prev_read = rd;
    if (rd) begin
      m_prev_word = m_next_word;
      m_next_word++;
    end
    m_hs = !(h >= HA + HF && h < HA + HF + HSW);
    m_vs = !(v >= VA + VF && v < VA + VF + VSW);
    if (act && empty_in) m_under = 1'b1;
    t++;
    @(posedge vga_clock);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input bit disp);
    vif.command = c;
    if (disp) disp_cycle(1'b0); else idle_tick();
    vectors++; if (vif.clear_command !== 1'b1) begin miscompares++; $display("FAIL ack_high cmd=%0d got %b expected 1", c, vif.clear_command); end
    vif.command = NOP;
    if (disp) disp_cycle(1'b0); else idle_tick();
    vectors++; if (vif.clear_command !== 1'b0) begin miscompares++; $display("FAIL ack_low cmd=%0d got %b expected 0", c, vif.clear_command); end
  endtask

  task automatic test_reset();
    vif.command = NOP;
    vif.fifo_level = 10'd0;
    vif.fifo_empty = 1'b0;
    reset = 1'b1;
    idle_tick();
    idle_tick();
    vectors++; if (vif.clear_command !== 1'b0) begin miscompares++; $display("FAIL rst_clear got %b expected 0", vif.clear_command); end
    vectors++; if (vif.enable_vga_fifo !== 1'b0) begin miscompares++; $display("FAIL rst_enable got %b expected 0", vif.enable_vga_fifo); end
    vectors++; if (vif.fifo_read !== 1'b0) begin miscompares++; $display("FAIL rst_read got %b expected 0", vif.fifo_read); end
    vectors++; if (vif.rgb !== 12'd0) begin miscompares++; $display("FAIL rst_rgb got %h expected 0", vif.rgb); end
    vectors++; if (vif.hsync !== 1'b1) begin miscompares++; $display("FAIL rst_hsync got %b expected 1", vif.hsync); end
    vectors++; if (vif.vsync !== 1'b1) begin miscompares++; $display("FAIL rst_vsync got %b expected 1", vif.vsync); end
    vectors++; if (vif.underflow !== 1'b0) begin miscompares++; $display("FAIL rst_underflow got %b expected 0", vif.underflow); end
    vectors++; if (vif.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b expected 0", vif.busy); end
    reset = 1'b0;
    idle_tick();
  endtask

  task automatic test_prepare_handshake();
    logic exp_clr;
    vif.fifo_level = 10'(PF - 1);
    vif.command = PREP;
    vectors++; if (vif.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b expected 0", vif.busy); end
    idle_tick();
    for (int i = 0; i < 10; i++) begin
      exp_clr = (i < 2);
      vectors++; if (vif.clear_command !== exp_clr) begin miscompares++; $display("FAIL prep_ack i=%0d got %b expected %b", i, vif.clear_command, exp_clr); end
      vectors++; if (vif.busy !== 1'b1 || vif.enable_vga_fifo !== 1'b1) begin miscompares++; $display("FAIL prefill_busy_en i=%0d got %b%b expected 11", i, vif.busy, vif.enable_vga_fifo); end
      vectors++; if (vif.fifo_read !== 1'b0 || vif.rgb !== 12'd0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin miscompares++; $display("FAIL prefill_outputs i=%0d got read=%b rgb=%h hs=%b vs=%b expected 0 000 1 1", i, vif.fifo_read, vif.rgb, vif.hsync, vif.vsync); end
      if (i == 1) vif.command = NOP;
      idle_tick();
    end
    vif.fifo_level = 10'(PF);
    #1;
    vectors++; if (vif.fifo_read !== 1'b0) begin miscompares++; $display("FAIL read_before_display got %b expected 0", vif.fifo_read); end
    idle_tick();
    model_start();
    m_under = 1'b0;
  endtask

  task automatic test_frame_clean();
    int reads = 0, hs_first = -1, hs_low = 0, vs_low = 0, tc;
    for (int c = 0; c < FRAME; c++) begin
      tc = t;
      disp_cycle(1'b0);
      if (obs_read) reads++;
      if (!obs_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = tc;
      end
      if (!obs_vs) vs_low++;
    end
    vectors++; if (reads != HA * VA) begin miscompares++; $display("FAIL frame_reads got %0d expected %0d", reads, HA * VA); end
    vectors++; if (hs_first != HA + HF + 1) begin miscompares++; $display("FAIL hsync_start got %0d expected %0d", hs_first, HA + HF + 1); end
    vectors++; if (hs_low != HSW * VT) begin miscompares++; $display("FAIL hsync_low_cycles got %0d expected %0d", hs_low, HSW * VT); end
    vectors++; if (vs_low != VSW * HT) begin miscompares++; $display("FAIL vsync_low_cycles got %0d expected %0d", vs_low, VSW * HT); end
  endtask

  task automatic test_underflow();
    int h, v;
    bit e;
    for (int c = 0; c < FRAME; c++) begin
      h = t % HT;
      v = (t / HT) % VT;
      e = (v == 3 && h >= 2 && h <= 5) || ($urandom_range(0, 9) == 0);
      disp_cycle(e);
    end
    vectors++; if (vif.underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set got %b expected 1", vif.underflow); end
    for (int c = 0; c < FRAME; c++) disp_cycle(1'b0);
    vectors++; if (vif.underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky got %b expected 1", vif.underflow); end
  endtask

  task automatic test_stop();
    int guard = 0;
    while (!((t / HT) % VT == 2 && t % HT == 0) && guard < FRAME) begin
      disp_cycle(1'b0);
      guard++;
    end
    send_cmd(STOP, 1'b1);
    send_cmd(PREP, 1'b1);
    guard = 0;
    while (t % FRAME != 0 && guard < 2 * FRAME) begin
      disp_cycle(1'b0);
      guard++;
    end
    vif.fifo_empty = 1'b0;
    #1;
    vectors++; if (vif.busy !== 1'b0 || vif.enable_vga_fifo !== 1'b0) begin miscompares++; $display("FAIL stop_idle got busy=%b en=%b expected 0 0", vif.busy, vif.enable_vga_fifo); end
    vectors++; if (vif.fifo_read !== 1'b0 || vif.rgb !== 12'd0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin miscompares++; $display("FAIL stop_outputs got read=%b rgb=%h hs=%b vs=%b expected 0 000 1 1", vif.fifo_read, vif.rgb, vif.hsync, vif.vsync); end
    vectors++; if (vif.underflow !== 1'b1) begin miscompares++; $display("FAIL stop_underflow got %b expected 1", vif.underflow); end
    for (int i = 0; i < 3; i++) begin
      idle_tick();
      vectors++; if (vif.busy !== 1'b0) begin miscompares++; $display("FAIL idle_stays i=%0d got %b expected 0", i, vif.busy); end
    end
  endtask

  task automatic test_prepare_clears_and_prefill_stop();
    vif.fifo_level = 10'd0;
    send_cmd(PREP, 1'b0);
    vectors++; if (vif.underflow !== 1'b0) begin miscompares++; $display("FAIL prep_clears_underflow got %b expected 0", vif.underflow); end
    vectors++; if (vif.busy !== 1'b1 || vif.enable_vga_fifo !== 1'b1) begin miscompares++; $display("FAIL prep2_busy_en got %b%b expected 11", vif.busy, vif.enable_vga_fifo); end
    vectors++; if (vif.fifo_read !== 1'b0 || vif.hsync !== 1'b1) begin miscompares++; $display("FAIL prep2_outputs got read=%b hs=%b expected 0 1", vif.fifo_read, vif.hsync); end
    send_cmd(STOP, 1'b0);
    vectors++; if (vif.busy !== 1'b0 || vif.enable_vga_fifo !== 1'b0) begin miscompares++; $display("FAIL prefill_stop got busy=%b en=%b expected 0 0", vif.busy, vif.enable_vga_fifo); end
  endtask

  task automatic test_reset_mid_handshake();
    int guard = 0;
    send_cmd(PREP, 1'b0);
    vif.fifo_level = 10'(PF);
    idle_tick();
    model_start();
    m_under = 1'b0;
    while (!((t / HT) % VT == 2 && t % HT == 5) && guard < FRAME) begin
      disp_cycle(t == 1);
      guard++;
    end
    vif.command = STOP;
    disp_cycle(1'b0);
    vectors++; if (vif.clear_command !== 1'b1 || vif.underflow !== 1'b1) begin miscompares++; $display("FAIL pre_reset got clr=%b uf=%b expected 1 1", vif.clear_command, vif.underflow); end
    #1;
    reset = 1'b1;
    #1;
    vectors++; if (vif.clear_command !== 1'b0 || vif.enable_vga_fifo !== 1'b0 || vif.busy !== 1'b0 || vif.underflow !== 1'b0) begin miscompares++; $display("FAIL async_reset_ctl got clr=%b en=%b busy=%b uf=%b expected 0 0 0 0", vif.clear_command, vif.enable_vga_fifo, vif.busy, vif.underflow); end
    vectors++; if (vif.fifo_read !== 1'b0 || vif.rgb !== 12'd0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin miscompares++; $display("FAIL async_reset_pix got read=%b rgb=%h hs=%b vs=%b expected 0 000 1 1", vif.fifo_read, vif.rgb, vif.hsync, vif.vsync); end
    idle_tick();
    reset = 1'b0;
    vectors++; if (vif.clear_command !== 1'b0) begin miscompares++; $display("FAIL release_clear got %b expected 0", vif.clear_command); end
    idle_tick();
    vectors++; if (vif.clear_command !== 1'b1 || vif.busy !== 1'b0 || vif.enable_vga_fifo !== 1'b0) begin miscompares++; $display("FAIL stop_in_idle got clr=%b busy=%b en=%b expected 1 0 0", vif.clear_command, vif.busy, vif.enable_vga_fifo); end
    vif.command = NOP;
    idle_tick();
    vectors++; if (vif.clear_command !== 1'b0 || vif.busy !== 1'b0) begin miscompares++; $display("FAIL stop_idle_release got clr=%b busy=%b expected 0 0", vif.clear_command, vif.busy); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_prepare_handshake();
    test_frame_clean();
    test_underflow();
    test_stop();
    test_prepare_clears_and_prefill_stop();
    test_reset_mid_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
